// File: rtl/multi_rename_unit.sv
// Dual-way register rename unit: ARF busy/tag table, RRF result store,
// tag allocation pointer, commit and flush handling, operand lookup.
module multi_rename_unit #(
  parameter int REG_NUM  = 32,
  parameter int RRF_NUM  = 64,
  parameter int DATA_LEN = 32,
  parameter int WB_PORTS = 5,
  localparam int REG_SEL = $clog2(REG_NUM),
  localparam int RRF_SEL = $clog2(RRF_NUM)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   dp_valid_i,
  input  logic                         stall_dp_i,
  input  logic [4*REG_SEL-1:0]         rs_idx_i,
  input  logic [2*REG_SEL-1:0]         rd_idx_i,
  input  logic [1:0]                   rd_en_i,
  output logic [4*DATA_LEN-1:0]        src_data_o,
  output logic [3:0]                   src_rdy_o,
  output logic                         alloc_ok_o,
  output logic [2*RRF_SEL-1:0]         rrftag_o,
  output logic [RRF_SEL:0]             freenum_o,
  output logic [RRF_SEL-1:0]           rrfptr_o,
  output logic                         nextrrfcyc_o,
  input  logic [WB_PORTS-1:0]          wb_we_i,
  input  logic [WB_PORTS*RRF_SEL-1:0]  wb_tag_i,
  input  logic [WB_PORTS*DATA_LEN-1:0] wb_data_i,
  input  logic [1:0]                   com_num_i,
  input  logic [1:0]                   com_we_i,
  input  logic [2*REG_SEL-1:0]         com_rd_i,
  input  logic [2*RRF_SEL-1:0]         com_tag_i,
  input  logic                         flush_i
);

  logic [DATA_LEN-1:0] arf_data_q [REG_NUM];
  logic [DATA_LEN-1:0] arf_data_d [REG_NUM];
  logic [RRF_SEL-1:0]  arf_tag_q  [REG_NUM];
  logic [RRF_SEL-1:0]  arf_tag_d  [REG_NUM];
  logic [REG_NUM-1:0]  arf_busy_q;
  logic [REG_NUM-1:0]  arf_busy_d;

  logic [DATA_LEN-1:0] rrf_data_q [RRF_NUM];
  logic [DATA_LEN-1:0] rrf_data_d [RRF_NUM];
  logic [RRF_NUM-1:0]  rrf_valid_q;
  logic [RRF_NUM-1:0]  rrf_valid_d;

  logic [RRF_SEL-1:0]  rrfptr_q;
  logic [RRF_SEL-1:0]  rrfptr_d;
  logic [RRF_SEL:0]    freenum_q;
  logic [RRF_SEL:0]    freenum_d;
  logic                nextrrfcyc_q;
  logic                nextrrfcyc_d;

  logic                fire;
  logic [1:0]          alloc_cnt;
  logic [RRF_SEL-1:0]  tag0;
  logic [RRF_SEL-1:0]  tag1;
  logic [REG_SEL-1:0]  rd0;
  logic [REG_SEL-1:0]  rd1;
  logic [1:0]          ren;
  logic [RRF_SEL:0]    ptr_sum;

  assign alloc_ok_o = freenum_q >= (RRF_SEL+1)'(2);
  assign fire       = alloc_ok_o & ~stall_dp_i & ~flush_i;
  assign alloc_cnt  = fire ? ({1'b0, dp_valid_i[0]} + {1'b0, dp_valid_i[1]})
                           : 2'd0;

  assign tag0 = rrfptr_q;
  assign tag1 = rrfptr_q + {{(RRF_SEL-1){1'b0}}, dp_valid_i[0]};
  assign rd0  = rd_idx_i[0 +: REG_SEL];
  assign rd1  = rd_idx_i[REG_SEL +: REG_SEL];

  // A way renames its rd only when it carries a real destination
  assign ren[0] = dp_valid_i[0] & rd_en_i[0] & (rd0 != '0);
  assign ren[1] = dp_valid_i[1] & rd_en_i[1] & (rd1 != '0);

  assign ptr_sum = {1'b0, rrfptr_q} + (RRF_SEL+1)'(alloc_cnt);

  assign rrftag_o     = {tag1, tag0};
  assign freenum_o    = freenum_q;
  assign rrfptr_o     = rrfptr_q;
  assign nextrrfcyc_o = nextrrfcyc_q;

  // Allocation pointer, wrap parity and free-entry count
  always_comb begin
    rrfptr_d     = ptr_sum[RRF_SEL-1:0];
    nextrrfcyc_d = nextrrfcyc_q ^ ptr_sum[RRF_SEL];
    freenum_d    = freenum_q
                 + (RRF_SEL+1)'(com_num_i)
                 - (RRF_SEL+1)'(alloc_cnt);
    if (flush_i) begin
      freenum_d = (RRF_SEL+1)'(RRF_NUM);
    end
  end

  // ARF update: commits first, renames override, flush drops busy
  always_comb begin
    logic [REG_SEL-1:0] crd;
    logic [RRF_SEL-1:0] ctag;
    arf_data_d = arf_data_q;
    arf_tag_d  = arf_tag_q;
    arf_busy_d = arf_busy_q;
    for (int s = 0; s < 2; s++) begin
      crd  = com_rd_i[s*REG_SEL +: REG_SEL];
      ctag = com_tag_i[s*RRF_SEL +: RRF_SEL];
      if (com_we_i[s] && crd != '0) begin
        arf_data_d[crd] = rrf_data_q[ctag];
        if (arf_tag_q[crd] == ctag) begin
          arf_busy_d[crd] = 1'b0;
        end
      end
    end
    if (fire && ren[0]) begin
      arf_busy_d[rd0] = 1'b1;
      arf_tag_d[rd0]  = tag0;
    end
    if (fire && ren[1]) begin
      arf_busy_d[rd1] = 1'b1;
      arf_tag_d[rd1]  = tag1;
    end
    if (flush_i) begin
      arf_busy_d = '0;
    end
  end

  // RRF update: writebacks land, freshly allocated entries start invalid
  always_comb begin
    logic [RRF_SEL-1:0] wtag;
    rrf_data_d  = rrf_data_q;
    rrf_valid_d = rrf_valid_q;
    for (int p = 0; p < WB_PORTS; p++) begin
      wtag = wb_tag_i[p*RRF_SEL +: RRF_SEL];
      if (wb_we_i[p]) begin
        rrf_valid_d[wtag] = 1'b1;
        rrf_data_d[wtag]  = wb_data_i[p*DATA_LEN +: DATA_LEN];
      end
    end
    if (fire && dp_valid_i[0]) begin
      rrf_valid_d[tag0] = 1'b0;
    end
    if (fire && dp_valid_i[1]) begin
      rrf_valid_d[tag1] = 1'b0;
    end
  end

  // Operand lookup for the four sources, highest priority first
  always_comb begin
    logic [REG_SEL-1:0]  sidx;
    logic [RRF_SEL-1:0]  stag;
    logic [DATA_LEN-1:0] sdat;
    logic                srdy;
    src_data_o = '0;
    src_rdy_o  = '0;
    for (int i = 0; i < 4; i++) begin
      sidx = rs_idx_i[i*REG_SEL +: REG_SEL];
      stag = arf_tag_q[sidx];
      sdat = '0;
      srdy = 1'b1;
      if (sidx == '0) begin
        sdat = '0;
      end else if (i >= 2 && ren[0] && sidx == rd0) begin
        sdat = DATA_LEN'(tag0);
        srdy = 1'b0;
      end else if (!arf_busy_q[sidx]) begin
        sdat = arf_data_q[sidx];
      end else if (rrf_valid_q[stag]) begin
        sdat = rrf_data_q[stag];
      end else begin
        sdat = DATA_LEN'(stag);
        srdy = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_we_i[p] && wb_tag_i[p*RRF_SEL +: RRF_SEL] == stag) begin
            sdat = wb_data_i[p*DATA_LEN +: DATA_LEN];
            srdy = 1'b1;
          end
        end
      end
      src_data_o[i*DATA_LEN +: DATA_LEN] = sdat;
      src_rdy_o[i] = srdy;
    end
  end

  // Architectural and control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        arf_data_q[r] <= '0;
        arf_tag_q[r]  <= '0;
      end
      arf_busy_q   <= '0;
      rrf_valid_q  <= '0;
      rrfptr_q     <= '0;
      freenum_q    <= (RRF_SEL+1)'(RRF_NUM);
      nextrrfcyc_q <= 1'b0;
    end else begin
      arf_data_q   <= arf_data_d;
      arf_tag_q    <= arf_tag_d;
      arf_busy_q   <= arf_busy_d;
      rrf_valid_q  <= rrf_valid_d;
      rrfptr_q     <= rrfptr_d;
      freenum_q    <= freenum_d;
      nextrrfcyc_q <= nextrrfcyc_d;
    end
  end

  // RRF payload needs no reset; readers qualify it with the valid bit
  always_ff @(posedge clk_i) begin
    rrf_data_q <= rrf_data_d;
  end

endmodule

// File: doc/multi_rename_unit.md
MULTI_RENAME_UNIT -- requirements
Module: multi_rename_unit

Interface
REQ-001 SHALL provide parameter REG_NUM, default 32, meaning architectural register count (REG_SEL = log2(REG_NUM)).
REQ-002 SHALL provide parameter RRF_NUM, default 64, meaning rename entry count, power of 2 (RRF_SEL = log2(RRF_NUM)).
REQ-003 SHALL provide parameter DATA_LEN, default 32, meaning operand width.
REQ-004 SHALL provide parameter WB_PORTS, default 5, meaning writeback/forward port count.
REQ-005 SHALL provide the following ports, clock and reset first:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- dp_valid_i  in  2  way0/way1 instruction present
- stall_dp_i  in  1  dispatch stall
- rs_idx_i  in  4*REG_SEL  sources {w1rs2,w1rs1,w0rs2,w0rs1}
- rd_idx_i  in  2*REG_SEL  destinations
- rd_en_i  in  2  destination write enable
- src_data_o  out  4*DATA_LEN  operand value, or zero-extended tag when not ready
- src_rdy_o  out  4  operand ready
- alloc_ok_o  out  1  freenum >= 2
- rrftag_o  out  2*RRF_SEL  tags allocated to way0/way1
- freenum_o  out  RRF_SEL+1  free entries
- rrfptr_o  out  RRF_SEL  next allocation pointer
- nextrrfcyc_o  out  1  registered wrap-parity bit
- wb_we_i  in  WB_PORTS  writeback enables
- wb_tag_i  in  WB_PORTS*RRF_SEL  writeback tags
- wb_data_i  in  WB_PORTS*DATA_LEN  writeback data
- com_num_i  in  2  entries retired this cycle (0..2)
- com_we_i  in  2  commit slot writes ARF
- com_rd_i  in  2*REG_SEL  commit slot destination
- com_tag_i  in  2*RRF_SEL  commit slot tag
- flush_i  in  1  pipeline flush

Function
REQ-006 SHALL define fire = alloc_ok_o & !stall_dp_i & !flush_i; alloc_cnt = fire ? popcount(dp_valid_i) : 0.
REQ-007 SHALL assign rrftag_o way0 = rrfptr; way1 = rrfptr+dp_valid_i[0], both modulo RRF_NUM.
REQ-008 SHALL update on each clock: rrfptr += alloc_cnt (mod RRF_NUM); freenum += com_num_i - alloc_cnt; nextrrfcyc_o toggles when the pointer add wraps.
REQ-009 SHALL, on fire, clear the RRF valid bit of each allocated tag.
REQ-010 SHALL, on fire, set ARF busy=1 and tag=allocated tag for each valid way with rd_en and rd!=0; same rd in both ways -> way1 wins.
REQ-011 SHALL, per enabled wb port, set RRF valid=1 and write data; on an equal-tag conflict the higher port index wins.
REQ-012 SHALL, per commit slot with com_we and rd!=0, copy RRF[com_tag] to ARF data, with slot1 over slot0 on equal rd.
REQ-013 SHALL, on commit, clear busy only when ARF tag==com_tag and no same-cycle rename targets that rd; rename wins.
REQ-014 SHALL resolve each source combinationally in priority order:
- reg 0 -> 0, rdy 1
- way1 source equal to a renamed way0 rd -> way0 tag, rdy 0
- not busy -> ARF data, rdy 1
- RRF valid -> RRF data, rdy 1
- matching wb port this cycle -> wb data, rdy 1
- else -> tag, rdy 0
REQ-015 SHALL never mark x0 busy, and SHALL read x0 as zero.
REQ-016 SHALL, on flush_i, clear all ARF busy bits, set freenum=RRF_NUM, and keep rrfptr; same-cycle commits still write ARF data; renames and allocation are discarded.
REQ-017 SHALL raise alloc_ok_o only when freenum >= 2, independent of dp_valid_i.

Reset
REQ-018 SHALL, on reset_i, set ARF data=0, busy=0, RRF valid=0, rrfptr=0, freenum=RRF_NUM, nextrrfcyc_o=0; reset overrides flush, fire and commit.

Verification
REQ-019 SHALL verify: reset, dual fire rd=5/rd=6 -> tags 0/1, freenum 62, rrfptr 2; next cycle rs1=5 -> rdy 0, data 0.
REQ-020 SHALL verify: wb port 3 tag 0 data 0xAB while rs1=5 is looked up -> same-cycle rdy 1, data 0xAB.
REQ-021 SHALL verify: way0 rd=7, way1 rs2=7 -> way1 src rdy 0, data = way0 tag.
REQ-022 SHALL verify: rrfptr=63, dual fire -> tags 63/0, rrfptr 1, nextrrfcyc_o toggles.
REQ-023 SHALL verify: freenum=1 -> alloc_ok_o=0, no state change; commit 2 -> freenum 3.
REQ-024 SHALL verify: flush with commit rd=5 tag 0 -> ARF[5]=RRF[0], all busy 0, freenum 64.
